// File: rtl/compute_seq.sv
// compute_seq: streams (a,b,x) triples into the compute engine (y=a*x+b),
// reads y back and presents it on a valid/ready output stream.
//
// Parameters: DATA_WIDTH, ADDR_WIDTH (compute port widths), CNT_WIDTH.
// Ports:
//   CLK, RST               clock, async active-low reset
//   s_valid_i/s_ready_o    operand stream handshake, s_a_i/s_b_i/s_x_i
//   m_valid_o/m_ready_i    result stream handshake, m_y_o
//   dina_o/addra_o/ena_o/wea_o/douta_i   compute memory-style port
//   busy_o                 not idle
//   count_o                completed output handshakes (wraps)
// Optional build macro CMPSEQ_REUSE_EN: skip writes of operands that
// already hold the same value inside compute.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 2
`endif

module compute_seq #(
   parameter int DATA_WIDTH = `DATA_WIDTH,
   parameter int ADDR_WIDTH = `ADDR_WIDTH,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  s_valid_i,
   output logic                  s_ready_o,
   input  logic [DATA_WIDTH-1:0] s_a_i,
   input  logic [DATA_WIDTH-1:0] s_b_i,
   input  logic [DATA_WIDTH-1:0] s_x_i,
   output logic                  m_valid_o,
   input  logic                  m_ready_i,
   output logic [DATA_WIDTH-1:0] m_y_o,
   output logic [DATA_WIDTH-1:0] dina_o,
   output logic [ADDR_WIDTH-1:0] addra_o,
   output logic                  ena_o,
   output logic                  wea_o,
   input  logic [DATA_WIDTH-1:0] douta_i,
   output logic                  busy_o,
   output logic [CNT_WIDTH-1:0]  count_o
);

   typedef enum logic [2:0] {
      IDLE,
      WR_A,
      WR_B,
      WR_X,
      RD,
      OUT
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] ADDR_A = ADDR_WIDTH'(0);
   localparam logic [ADDR_WIDTH-1:0] ADDR_B = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_X = ADDR_WIDTH'(2);
   localparam logic [ADDR_WIDTH-1:0] ADDR_Y = ADDR_WIDTH'(0);

   state_t                state_q;
   state_t                state_d;
   logic [DATA_WIDTH-1:0] a_q;
   logic [DATA_WIDTH-1:0] b_q;
   logic [DATA_WIDTH-1:0] x_q;
   logic [DATA_WIDTH-1:0] y_q;
   logic [CNT_WIDTH-1:0]  cnt_q;

   logic in_hs;
   logic out_hs;

   // need_*_in decide the first write from IDLE using the incoming
   // operands; need_b/need_x decide later steps from the latched ones.
   logic need_a_in;
   logic need_b_in;
   logic need_x_in;
   logic need_b;
   logic need_x;

   assign in_hs  = (state_q == IDLE) && s_valid_i;
   assign out_hs = (state_q == OUT) && m_ready_i;

`ifdef CMPSEQ_REUSE_EN
   // Mirror of what compute currently holds; compute shares RST, so
   // both start at 0.
   logic [DATA_WIDTH-1:0] sa_q;
   logic [DATA_WIDTH-1:0] sb_q;
   logic [DATA_WIDTH-1:0] sx_q;

   assign need_a_in = (s_a_i != sa_q);
   assign need_b_in = (s_b_i != sb_q);
   assign need_x_in = (s_x_i != sx_q);
   assign need_b    = (b_q != sb_q);
   assign need_x    = (x_q != sx_q);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sa_q <= '0;
         sb_q <= '0;
         sx_q <= '0;
      end else begin
         if (state_q == WR_A) sa_q <= a_q;
         if (state_q == WR_B) sb_q <= b_q;
         if (state_q == WR_X) sx_q <= x_q;
      end
   end
`else
   assign need_a_in = 1'b1;
   assign need_b_in = 1'b1;
   assign need_x_in = 1'b1;
   assign need_b    = 1'b1;
   assign need_x    = 1'b1;
`endif

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      dina_o  = '0;
      addra_o = '0;
      ena_o   = 1'b0;
      wea_o   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (s_valid_i) begin
               if (need_a_in)      state_d = WR_A;
               else if (need_b_in) state_d = WR_B;
               else if (need_x_in) state_d = WR_X;
               else                state_d = RD;
            end
         end
         WR_A: begin
            ena_o   = 1'b1;
            wea_o   = 1'b1;
            addra_o = ADDR_A;
            dina_o  = a_q;
            if (need_b)      state_d = WR_B;
            else if (need_x) state_d = WR_X;
            else             state_d = RD;
         end
         WR_B: begin
            ena_o   = 1'b1;
            wea_o   = 1'b1;
            addra_o = ADDR_B;
            dina_o  = b_q;
            if (need_x) state_d = WR_X;
            else        state_d = RD;
         end
         WR_X: begin
            ena_o   = 1'b1;
            wea_o   = 1'b1;
            addra_o = ADDR_X;
            dina_o  = x_q;
            state_d = RD;
         end
         RD: begin
            ena_o   = 1'b1;
            addra_o = ADDR_Y;
            state_d = OUT;
         end
         OUT: begin
            if (m_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         a_q <= '0;
         b_q <= '0;
         x_q <= '0;
      end else if (in_hs) begin
         a_q <= s_a_i;
         b_q <= s_b_i;
         x_q <= s_x_i;
      end
   end

   // Result is held until the next read, so it survives IDLE.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         y_q <= '0;
      end else if (state_q == RD) begin
         y_q <= douta_i;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         cnt_q <= '0;
      end else if (out_hs) begin
         cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
   end

   assign s_ready_o = (state_q == IDLE);
   assign m_valid_o = (state_q == OUT);
   assign busy_o    = (state_q != IDLE);
   assign m_y_o     = y_q;
   assign count_o   = cnt_q;

endmodule

// File: doc/compute_seq.md
# compute_seq

Sequencer that sits directly upstream of the `compute` engine (y = a·x + b) and drives its memory-style port. It accepts operand triples on a valid/ready input stream, writes a, b and x into `compute` registers 0/1/2, reads the result back, and presents it on a valid/ready output stream. Software and stream sources therefore never touch the `compute` address map directly.

## Interface
Parameters:
- DATA_WIDTH, default `` `DATA_WIDTH `` (common.vh): operand and result width.
- ADDR_WIDTH, default `` `ADDR_WIDTH `` (common.vh): `compute` address width.
- CNT_WIDTH, default 16: width of the completed-transaction counter.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- s_valid_i  in  1  operand triple valid.
- s_ready_o  out  1  sequencer can accept a triple.
- s_a_i, s_b_i, s_x_i  in  DATA_WIDTH each  operands.
- m_valid_o  out  1  result valid.
- m_ready_i  in  1  consumer accepts the result.
- m_y_o  out  DATA_WIDTH  result.
- dina_o  out  DATA_WIDTH  write data to `compute`.
- addra_o  out  ADDR_WIDTH  address to `compute`.
- ena_o, wea_o  out  1 each  enable and write-enable to `compute`.
- douta_i  in  DATA_WIDTH  combinational read data from `compute`.
- busy_o  out  1  state is not IDLE.
- count_o  out  CNT_WIDTH  number of completed output handshakes.

## Operation
- FSM states: IDLE, WR_A, WR_B, WR_X, RD, OUT.
- IDLE:
  - s_ready_o=1.
  - On s_valid_i, latch a, b and x, then go to the first write state (WR_A).
- WR_A: ena=1, wea=1, addra=0, dina=a. Next state WR_B.
- WR_B: ena=1, wea=1, addra=1, dina=b. Next state WR_X.
- WR_X: ena=1, wea=1, addra=2, dina=x. Next state RD.
- RD: ena=1, wea=0, addra=0. Capture douta_i into m_y_o at the end of the cycle, then go to OUT.
- OUT:
  - m_valid_o=1.
  - On m_ready_i, increment count_o and go to IDLE.
  - count_o wraps from 2^CNT_WIDTH−1 to 0.
- Bus idle value: in IDLE and OUT, dina_o, addra_o, ena_o and wea_o are all 0.
- Arithmetic: the result is a·x+b truncated to DATA_WIDTH, as produced by `compute`. The sequencer does not modify it.
- s_ready_o is 0 in every state except IDLE. Triples presented while busy are held off, never dropped.
- m_y_o holds its value from the capture until the next RD capture, including across IDLE.
- Shared reset: `compute` shares RST, so its registers are 0 whenever this block is reset.

## Timing
- Reset values:
  - State IDLE.
  - s_ready_o=1.
  - m_valid_o=0, m_y_o=0, count_o=0, busy_o=0.
  - All bus outputs 0.
  - Operand latches and shadow registers 0.
- Latency: input handshake at edge E0 → WR_A in cycle E0..E1 → RD in cycle E3..E4 → m_valid_o=1 after E4. That is 4 cycles from input handshake to m_valid_o.
- Throughput: at best one triple per 6 cycles with m_ready_i held high. The next s_ready_o goes high the cycle after the output handshake.
- Output stability: while m_valid_o=1 and m_ready_i=0, m_y_o is stable.
- No combinational paths from s_valid_i or m_ready_i to any output.
- Reset mid-operation: RST low in any state aborts immediately and restores the reset values. Any partially written operands are discarded; `compute` is reset as well.

## Configuration
- Macro `CMPSEQ_REUSE_EN`.
- Defined:
  - The block keeps shadow registers of the last a, b and x written to `compute` (reset 0, matching `compute` reset).
  - Each WR_* state whose operand equals its shadow is skipped; the next needed state follows directly.
  - If all three operands match, IDLE goes straight to RD.
  - Latency = 1 + number of writes performed (1..4 cycles).
  - Shadows update only when the corresponding write is issued.
- Undefined: no shadow registers, all three writes always issued, latency fixed at 4.

## Test plan
- Basic: after reset, a=3, b=5, x=7 → write sequence addr 0/1/2 with data 3/5/7, read at addr 0, m_y_o=26 with m_valid_o rising 4 cycles after the input handshake; count_o=1 after m_ready_i.
- Truncation (DATA_WIDTH=32): a=0xFFFFFFFF, x=2, b=3 → m_y_o=0x00000001.
- Backpressure:
  - Hold m_ready_i=0 for 5 cycles after m_valid_o → m_valid_o stays 1, m_y_o stable, s_ready_o=0 throughout.
  - A pending s_valid_i is accepted only the cycle after m_ready_i.
- Back-to-back: two triples (1,1,1) then (2,0,4) with m_ready_i=1 → results 2 then 8, count_o=2, second input handshake exactly 6 cycles after the first.
- Reset mid-op: assert RST in WR_B → all outputs return to reset values. After release, a new triple (2,2,2) yields 6.
- `CMPSEQ_REUSE_EN` defined:
  - (3,5,7) then (3,9,7) → second transaction issues only the addr 1 write, m_y_o=30, latency 2.
  - (0,0,0) after reset → no writes issued, m_y_o=0, latency 1.
